// File: rtl/ysyx_23060025_axi_arbiter.sv
// ysyx_23060025_axi_arbiter
//   Shares one AXI4-Lite memory port between the IFU (m0, read-only) and the
//   LSU (m1, read + write). One master is granted at a time, and it keeps the
//   grant until its response handshake completes. Each slave response is
//   routed only to the granted master.
//
// Ports
//   clock, rstn         system clock, synchronous active-low reset
//   m0_ar*/m0_r*        IFU read address / read data channels
//   m1_ar*/m1_r*        LSU read address / read data channels
//   m1_aw*/m1_w*/m1_b*  LSU write address / write data / write response channels
//   s_*                 shared slave-side channels toward memory / xbar
//
// state  | meaning
// IDLE   | no grant; fixed-priority pick among m1 write, m1 read, m0 read
// RD_M0  | IFU read granted; AR and R pass through to m0
// RD_M1  | LSU read granted; AR and R pass through to m1
// WR_M1  | LSU write granted; AW, W and B pass through to m1
module ysyx_23060025_axi_arbiter #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                  clock,
  input  logic                  rstn,
  // IFU read
  input  logic [ADDR_LEN-1:0]   m0_araddr_i,
  input  logic                  m0_arvalid_i,
  input  logic [2:0]            m0_arsize_i,
  output logic                  m0_arready_o,
  output logic [DATA_LEN-1:0]   m0_rdata_o,
  output logic [1:0]            m0_rresp_o,
  output logic                  m0_rvalid_o,
  input  logic                  m0_rready_i,
  // LSU read
  input  logic [ADDR_LEN-1:0]   m1_araddr_i,
  input  logic                  m1_arvalid_i,
  input  logic [2:0]            m1_arsize_i,
  output logic                  m1_arready_o,
  output logic [DATA_LEN-1:0]   m1_rdata_o,
  output logic [1:0]            m1_rresp_o,
  output logic                  m1_rvalid_o,
  input  logic                  m1_rready_i,
  // LSU write
  input  logic [ADDR_LEN-1:0]   m1_awaddr_i,
  input  logic                  m1_awvalid_i,
  input  logic [2:0]            m1_awsize_i,
  output logic                  m1_awready_o,
  input  logic [DATA_LEN-1:0]   m1_wdata_i,
  input  logic [DATA_LEN/8-1:0] m1_wstrb_i,
  input  logic                  m1_wvalid_i,
  output logic                  m1_wready_o,
  output logic [1:0]            m1_bresp_o,
  output logic                  m1_bvalid_o,
  input  logic                  m1_bready_i,
  // slave side
  output logic [ADDR_LEN-1:0]   s_araddr_o,
  output logic                  s_arvalid_o,
  output logic [2:0]            s_arsize_o,
  input  logic                  s_arready_i,
  input  logic [DATA_LEN-1:0]   s_rdata_i,
  input  logic [1:0]            s_rresp_i,
  input  logic                  s_rvalid_i,
  output logic                  s_rready_o,
  output logic [ADDR_LEN-1:0]   s_awaddr_o,
  output logic                  s_awvalid_o,
  output logic [2:0]            s_awsize_o,
  input  logic                  s_awready_i,
  output logic [DATA_LEN-1:0]   s_wdata_o,
  output logic [DATA_LEN/8-1:0] s_wstrb_o,
  output logic                  s_wvalid_o,
  input  logic                  s_wready_i,
  input  logic [1:0]            s_bresp_i,
  input  logic                  s_bvalid_i,
  output logic                  s_bready_o
);

  typedef enum logic [1:0] {IDLE, RD_M0, RD_M1, WR_M1} state_e;

  state_e state_q, state_d;
  logic   ar_done_q, ar_done_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  // Grants are qualified with rstn so that nothing is forwarded or accepted
  // while reset is held, even before the state register returns to IDLE.
  logic g_rd0, g_rd1, g_wr;
  assign g_rd0 = rstn && (state_q == RD_M0);
  assign g_rd1 = rstn && (state_q == RD_M1);
  assign g_wr  = rstn && (state_q == WR_M1);

  // Read path
  always_comb begin
    s_araddr_o  = '0;
    s_arsize_o  = '0;
    s_arvalid_o = 1'b0;
    s_rready_o  = 1'b0;
    if (g_rd0) begin
      s_araddr_o  = m0_araddr_i;
      s_arsize_o  = m0_arsize_i;
      s_arvalid_o = m0_arvalid_i && !ar_done_q;
      s_rready_o  = m0_rready_i;
    end else if (g_rd1) begin
      s_araddr_o  = m1_araddr_i;
      s_arsize_o  = m1_arsize_i;
      s_arvalid_o = m1_arvalid_i && !ar_done_q;
      s_rready_o  = m1_rready_i;
    end
  end

  assign m0_arready_o = g_rd0 && !ar_done_q && s_arready_i;
  assign m0_rvalid_o  = g_rd0 && s_rvalid_i;
  assign m0_rdata_o   = g_rd0 ? s_rdata_i : '0;
  assign m0_rresp_o   = g_rd0 ? s_rresp_i : '0;

  assign m1_arready_o = g_rd1 && !ar_done_q && s_arready_i;
  assign m1_rvalid_o  = g_rd1 && s_rvalid_i;
  assign m1_rdata_o   = g_rd1 ? s_rdata_i : '0;
  assign m1_rresp_o   = g_rd1 ? s_rresp_i : '0;

  // Write path: AW and W complete independently, each blanked once done.
  assign s_awaddr_o   = g_wr ? m1_awaddr_i : '0;
  assign s_awsize_o   = g_wr ? m1_awsize_i : '0;
  assign s_awvalid_o  = g_wr && m1_awvalid_i && !aw_done_q;
  assign s_wdata_o    = g_wr ? m1_wdata_i : '0;
  assign s_wstrb_o    = g_wr ? m1_wstrb_i : '0;
  assign s_wvalid_o   = g_wr && m1_wvalid_i && !w_done_q;
  assign s_bready_o   = g_wr && m1_bready_i;

  assign m1_awready_o = g_wr && !aw_done_q && s_awready_i;
  assign m1_wready_o  = g_wr && !w_done_q && s_wready_i;
  assign m1_bvalid_o  = g_wr && s_bvalid_i;
  assign m1_bresp_o   = g_wr ? s_bresp_i : '0;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  assign ar_hs = s_arvalid_o && s_arready_i;
  assign r_hs  = s_rvalid_i && s_rready_o;
  assign aw_hs = s_awvalid_o && s_awready_i;
  assign w_hs  = s_wvalid_o && s_wready_i;
  assign b_hs  = s_bvalid_i && s_bready_o;

  // Returning to IDLE on the response handshake (rather than granting the
  // next master directly) guarantees a gap cycle and keeps the response path
  // out of the request-side logic.
  always_comb begin
    state_d   = state_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (m1_awvalid_i || m1_wvalid_i) state_d = WR_M1;
        else if (m1_arvalid_i)           state_d = RD_M1;
        else if (m0_arvalid_i)           state_d = RD_M0;
      end
      RD_M0, RD_M1: begin
        if (ar_hs) ar_done_d = 1'b1;
        if (r_hs) begin
          state_d   = IDLE;
          ar_done_d = 1'b0;
        end
      end
      WR_M1: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (b_hs) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      state_q   <= IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_axi_arbiter.sv
// Self-checking bench for ysyx_23060025_axi_arbiter: directed scenarios plus
// randomized bursts of concurrent requests served by a behavioural slave.
module tb_ysyx_23060025_axi_arbiter;

  logic clock = 1'b0;
  logic rstn;
  always #5 clock = ~clock;

  logic [31:0] m0_araddr_i, m1_araddr_i, m1_awaddr_i, m1_wdata_i;
  logic        m0_arvalid_i, m1_arvalid_i, m1_awvalid_i, m1_wvalid_i;
  logic [2:0]  m0_arsize_i, m1_arsize_i, m1_awsize_i;
  logic [3:0]  m1_wstrb_i;
  logic        m0_rready_i, m1_rready_i, m1_bready_i;
  logic        m0_arready_o, m0_rvalid_o, m1_arready_o, m1_rvalid_o;
  logic        m1_awready_o, m1_wready_o, m1_bvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic [1:0]  m0_rresp_o, m1_rresp_o, m1_bresp_o;
  logic [31:0] s_araddr_o, s_awaddr_o, s_wdata_o, s_rdata_i;
  logic [2:0]  s_arsize_o, s_awsize_o;
  logic [3:0]  s_wstrb_o;
  logic        s_arvalid_o, s_rready_o, s_awvalid_o, s_wvalid_o, s_bready_o;
  logic        s_arready_i, s_rvalid_i, s_awready_i, s_wready_i, s_bvalid_i;
  logic [1:0]  s_rresp_i, s_bresp_i;

  ysyx_23060025_axi_arbiter dut (
    .clock(clock), .rstn(rstn),
    .m0_araddr_i(m0_araddr_i), .m0_arvalid_i(m0_arvalid_i), .m0_arsize_i(m0_arsize_i),
    .m0_arready_o(m0_arready_o), .m0_rdata_o(m0_rdata_o), .m0_rresp_o(m0_rresp_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rready_i(m0_rready_i),
    .m1_araddr_i(m1_araddr_i), .m1_arvalid_i(m1_arvalid_i), .m1_arsize_i(m1_arsize_i),
    .m1_arready_o(m1_arready_o), .m1_rdata_o(m1_rdata_o), .m1_rresp_o(m1_rresp_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rready_i(m1_rready_i),
    .m1_awaddr_i(m1_awaddr_i), .m1_awvalid_i(m1_awvalid_i), .m1_awsize_i(m1_awsize_i),
    .m1_awready_o(m1_awready_o), .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i),
    .m1_wvalid_i(m1_wvalid_i), .m1_wready_o(m1_wready_o), .m1_bresp_o(m1_bresp_o),
    .m1_bvalid_o(m1_bvalid_o), .m1_bready_i(m1_bready_i),
    .s_araddr_o(s_araddr_o), .s_arvalid_o(s_arvalid_o), .s_arsize_o(s_arsize_o),
    .s_arready_i(s_arready_i), .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i),
    .s_rvalid_i(s_rvalid_i), .s_rready_o(s_rready_o),
    .s_awaddr_o(s_awaddr_o), .s_awvalid_o(s_awvalid_o), .s_awsize_o(s_awsize_o),
    .s_awready_i(s_awready_i), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
    .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready_i), .s_bresp_i(s_bresp_i),
    .s_bvalid_i(s_bvalid_i), .s_bready_o(s_bready_o)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic cyc();
    @(posedge clock);
    #1;
    cyc_n++;
  endtask

  task automatic clr();
    m0_araddr_i = '0; m0_arvalid_i = 0; m0_arsize_i = '0; m0_rready_i = 0;
    m1_araddr_i = '0; m1_arvalid_i = 0; m1_arsize_i = '0; m1_rready_i = 0;
    m1_awaddr_i = '0; m1_awvalid_i = 0; m1_awsize_i = '0;
    m1_wdata_i = '0; m1_wstrb_i = '0; m1_wvalid_i = 0; m1_bready_i = 0;
    s_arready_i = 0; s_rvalid_i = 0; s_rdata_i = '0; s_rresp_i = '0;
    s_awready_i = 0; s_wready_i = 0; s_bvalid_i = 0; s_bresp_i = '0;
  endtask

  // Transactions are served strictly one at a time in priority order
  // (m1 write, m1 read, m0 read). A transaction's slave-side valid first
  // appears one cycle after its request (from idle) or two cycles after the
  // previous transaction's response handshake.
  task automatic run_random(input int n_iter);
    for (int it = 0; it < n_iter; it++) begin
      int mask, start_c, budget, cur;
      int order[$];
      logic [31:0] a0, a1, aw, wd, exp_addr;
      logic [3:0]  ws;
      bit p0_ar, p1_ar, pw_aw, pw_w, done;
      bit sl_rb, sl_awg, sl_wg;
      int sl_rc, sl_bc;
      logic [31:0] sl_ra, sl_wa, sl_wd;
      logic [3:0]  sl_ws;
      logic [1:0]  sl_rr, sl_br;
      bit ar_hs, r_hs, aw_hs, w_hs, b_hs;

      mask = (it < 7) ? it + 1 : int'($urandom_range(1, 7));
      a0 = 32'h2000_0000 | ($urandom & 32'h00FF_FFFC);
      a1 = 32'h8000_0000 | ($urandom & 32'h00FF_FFFC);
      aw = 32'hC000_0000 | ($urandom & 32'h00FF_FFFC);
      wd = $urandom;
      ws = 4'($urandom);
      order.delete();
      if (mask[2]) order.push_back(2);
      if (mask[1]) order.push_back(1);
      if (mask[0]) order.push_back(0);
      p0_ar = mask[0]; p1_ar = mask[1]; pw_aw = mask[2]; pw_w = mask[2];
      sl_rb = 0; sl_awg = 0; sl_wg = 0; sl_rc = 0; sl_bc = 0;
      sl_ra = '0; sl_wa = '0; sl_wd = '0; sl_ws = '0; sl_rr = '0; sl_br = '0;
      repeat ($urandom_range(0, 2)) cyc();
      start_c = cyc_n + 1;
      budget = 0;
      while (order.size() > 0 && budget < 300) begin
        cur = order[0];
        exp_addr = (cur == 0) ? a0 : a1;
        m0_arvalid_i = p0_ar; m0_araddr_i = a0; m0_arsize_i = 3'd2;
        m0_rready_i  = 1'($urandom_range(0, 1));
        m1_arvalid_i = p1_ar; m1_araddr_i = a1; m1_arsize_i = 3'd2;
        m1_rready_i  = 1'($urandom_range(0, 1));
        m1_awvalid_i = pw_aw; m1_awaddr_i = aw; m1_awsize_i = 3'd2;
        m1_wvalid_i  = pw_w; m1_wdata_i = wd; m1_wstrb_i = ws;
        m1_bready_i  = 1'($urandom_range(0, 1));
        s_arready_i  = !sl_rb && 1'($urandom_range(0, 1));
        s_rvalid_i   = sl_rb && sl_rc == 0;
        s_rdata_i    = sl_rb ? ~sl_ra : $urandom;
        s_rresp_i    = sl_rr;
        s_awready_i  = !sl_awg && 1'($urandom_range(0, 1));
        s_wready_i   = !sl_wg && 1'($urandom_range(0, 1));
        s_bvalid_i   = sl_awg && sl_wg && sl_bc == 0;
        s_bresp_i    = sl_br;
        #1;
        if (cyc_n < start_c)
          chk("rnd_gap_idle", 32'({s_arvalid_o, s_awvalid_o, s_wvalid_o, s_rready_o, s_bready_o}), 32'd0);
        else if (cyc_n == start_c)
          chk("rnd_grant_start", 32'(cur == 2 ? (s_awvalid_o | s_wvalid_o) : s_arvalid_o), 32'd1);
        if (cur == 2) chk("rnd_wr_no_ar", 32'(s_arvalid_o), 32'd0);
        else          chk("rnd_rd_no_aw", 32'(s_awvalid_o | s_wvalid_o), 32'd0);
        if (cur != 0) chk("rnd_m0_quiet", 32'(m0_arready_o | m0_rvalid_o), 32'd0);
        if (s_arvalid_o) chk("rnd_araddr", s_araddr_o, exp_addr);
        if (s_rvalid_i) begin
          chk("rnd_rvalid_route", 32'({m1_rvalid_o, m0_rvalid_o}), (cur == 0) ? 32'd1 : 32'd2);
          chk("rnd_rdata", (cur == 0) ? m0_rdata_o : m1_rdata_o, ~exp_addr);
          chk("rnd_rresp", 32'((cur == 0) ? m0_rresp_o : m1_rresp_o), 32'(sl_rr));
          chk("rnd_rready", 32'(s_rready_o), 32'((cur == 0) ? m0_rready_i : m1_rready_i));
        end
        if (s_bvalid_i) begin
          chk("rnd_bvalid", 32'(m1_bvalid_o), 32'd1);
          chk("rnd_bresp", 32'(m1_bresp_o), 32'(sl_br));
          chk("rnd_bready", 32'(s_bready_o), 32'(m1_bready_i));
        end
        ar_hs = s_arvalid_o && s_arready_i;
        r_hs  = s_rvalid_i && s_rready_o;
        aw_hs = s_awvalid_o && s_awready_i;
        w_hs  = s_wvalid_o && s_wready_i;
        b_hs  = s_bvalid_i && s_bready_o;
        done  = 0;
        if (m0_rvalid_o && m0_rready_i) begin chk("rnd_order_m0", 32'(cur), 32'd0); done = 1; end
        if (m1_rvalid_o && m1_rready_i) begin chk("rnd_order_m1r", 32'(cur), 32'd1); done = 1; end
        if (m1_bvalid_o && m1_bready_i) begin
          chk("rnd_order_m1w", 32'(cur), 32'd2);
          chk("rnd_slave_awaddr", sl_wa, aw);
          chk("rnd_slave_wdata", sl_wd, wd);
          chk("rnd_slave_wstrb", 32'(sl_ws), 32'(ws));
          done = 1;
        end
        if (m0_arvalid_i && m0_arready_o) p0_ar = 0;
        if (m1_arvalid_i && m1_arready_o) p1_ar = 0;
        if (m1_awvalid_i && m1_awready_o) pw_aw = 0;
        if (m1_wvalid_i && m1_wready_o)   pw_w = 0;
        if (ar_hs) begin
          sl_rb = 1; sl_ra = s_araddr_o;
          sl_rc = int'($urandom_range(0, 3)); sl_rr = 2'($urandom_range(0, 3));
        end else if (sl_rb && sl_rc > 0) sl_rc--;
        if (r_hs) sl_rb = 0;
        if (aw_hs) begin sl_awg = 1; sl_wa = s_awaddr_o; end
        if (w_hs)  begin sl_wg = 1; sl_wd = s_wdata_o; sl_ws = s_wstrb_o; end
        if (aw_hs || w_hs) begin
          sl_bc = int'($urandom_range(0, 3)); sl_br = 2'($urandom_range(0, 3));
        end else if (sl_awg && sl_wg && sl_bc > 0) sl_bc--;
        if (b_hs) begin sl_awg = 0; sl_wg = 0; end
        if (done) begin
          void'(order.pop_front());
          start_c = cyc_n + 2;
        end
        cyc();
        budget++;
      end
      chk("rnd_all_done", 32'(order.size()), 32'd0);
      clr();
      #1;
      chk("rnd_back_idle", 32'({s_arvalid_o, s_awvalid_o, s_wvalid_o, s_rready_o, s_bready_o}), 32'd0);
    end
  endtask

  initial begin
    // Reset: everything quiet even with requests and responses present.
    clr();
    rstn = 0;
    m0_arvalid_i = 1; m1_awvalid_i = 1; m1_wvalid_i = 1; s_rvalid_i = 1; s_bvalid_i = 1;
    m0_rready_i = 1; m1_bready_i = 1; s_arready_i = 1; s_awready_i = 1;
    repeat (2) cyc();
    #1;
    chk("rst_s_valids", 32'({s_arvalid_o, s_awvalid_o, s_wvalid_o}), 32'd0);
    chk("rst_s_readies", 32'({s_rready_o, s_bready_o}), 32'd0);
    chk("rst_m_outs", 32'({m0_arready_o, m0_rvalid_o, m1_arready_o, m1_rvalid_o,
                           m1_awready_o, m1_wready_o, m1_bvalid_o}), 32'd0);
    chk("rst_addr", s_araddr_o | s_awaddr_o | s_wdata_o, 32'd0);
    clr();
    rstn = 1;
    cyc();

    // Stray slave responses in IDLE are neither forwarded nor accepted.
    s_rvalid_i = 1; s_bvalid_i = 1; m0_rready_i = 1; m1_rready_i = 1; m1_bready_i = 1;
    #1;
    chk("idle_stray_rvalid", 32'({m0_rvalid_o, m1_rvalid_o, m1_bvalid_o}), 32'd0);
    chk("idle_stray_ready", 32'({s_rready_o, s_bready_o}), 32'd0);
    cyc(); clr();

    // IFU read alone.
    m0_araddr_i = 32'h2000_0000; m0_arsize_i = 3'd2; m0_arvalid_i = 1;
    #1 chk("ifu_c0_no_fwd", 32'(s_arvalid_o), 32'd0);
    cyc(); s_arready_i = 1;
    #1;
    chk("ifu_c1_arvalid", 32'(s_arvalid_o), 32'd1);
    chk("ifu_c1_araddr", s_araddr_o, 32'h2000_0000);
    chk("ifu_c1_arsize", 32'(s_arsize_o), 32'd2);
    chk("ifu_c1_arready", 32'({m0_arready_o, m1_arready_o}), 32'd2);
    cyc(); s_arready_i = 0;
    #1 chk("ifu_ar_done_gate", 32'({s_arvalid_o, m0_arready_o}), 32'd0);
    cyc(); m0_arvalid_i = 0; s_rvalid_i = 1; s_rdata_i = 32'hDEAD_BEEF; m0_rready_i = 1; m1_rready_i = 1;
    #1;
    chk("ifu_rvalid", 32'(m0_rvalid_o), 32'd1);
    chk("ifu_rdata", m0_rdata_o, 32'hDEAD_BEEF);
    chk("ifu_m1_quiet", 32'(m1_rvalid_o), 32'd0);
    chk("ifu_m1_rdata_zero", m1_rdata_o, 32'd0);
    chk("ifu_s_rready", 32'(s_rready_o), 32'd1);
    cyc();
    #1 chk("ifu_exit_idle", 32'({m0_rvalid_o, s_rready_o}), 32'd0);
    cyc(); clr();

    // LSU store: AW accepted three cycles before W.
    m1_awaddr_i = 32'h8000_0010; m1_awsize_i = 3'd2; m1_awvalid_i = 1;
    m1_wdata_i = 32'h1234_5678; m1_wstrb_i = 4'hF; m1_wvalid_i = 1;
    #1 chk("sw_c0_no_fwd", 32'({s_awvalid_o, s_wvalid_o}), 32'd0);
    cyc(); s_awready_i = 1;
    #1;
    chk("sw_c1_valids", 32'({s_awvalid_o, s_wvalid_o}), 32'd3);
    chk("sw_c1_awaddr", s_awaddr_o, 32'h8000_0010);
    chk("sw_c1_wdata", s_wdata_o, 32'h1234_5678);
    chk("sw_c1_wstrb", 32'(s_wstrb_o), 32'hF);
    chk("sw_c1_readies", 32'({m1_awready_o, m1_wready_o}), 32'd2);
    for (int k = 0; k < 2; k++) begin
      cyc(); s_awready_i = 0;
      #1 chk("sw_aw_gated", 32'({s_awvalid_o, s_wvalid_o}), 32'd1);
    end
    cyc(); s_wready_i = 1;
    #1 chk("sw_w_hs", 32'({s_awvalid_o, s_wvalid_o, m1_wready_o}), 32'd3);
    cyc(); s_wready_i = 0;
    #1 chk("sw_both_gated", 32'({s_awvalid_o, s_wvalid_o, m1_bvalid_o}), 32'd0);
    cyc(); m1_awvalid_i = 0; m1_wvalid_i = 0; s_bvalid_i = 1; m1_bready_i = 1;
    #1;
    chk("sw_bvalid", 32'({m1_bvalid_o, s_bready_o}), 32'd3);
    chk("sw_bresp", 32'(m1_bresp_o), 32'd0);
    cyc();
    #1 chk("sw_exit_idle", 32'({m1_bvalid_o, s_bready_o}), 32'd0);
    cyc(); clr();

    // AW and W in the same cycle; SLVERR response forwarded and still ends it.
    m1_awaddr_i = 32'h8000_0020; m1_awvalid_i = 1; m1_wdata_i = 32'hA5A5_5A5A;
    m1_wstrb_i = 4'h3; m1_wvalid_i = 1;
    cyc(); s_awready_i = 1; s_wready_i = 1;
    #1 chk("sw2_same_cycle", 32'({m1_awready_o, m1_wready_o}), 32'd3);
    cyc(); m1_awvalid_i = 0; m1_wvalid_i = 0; s_awready_i = 0; s_wready_i = 0;
    s_bvalid_i = 1; s_bresp_i = 2'b10; m1_bready_i = 1;
    #1;
    chk("sw2_bresp", 32'(m1_bresp_o), 32'd2);
    chk("sw2_bvalid", 32'(m1_bvalid_o), 32'd1);
    cyc();
    #1 chk("sw2_exit_idle", 32'({m1_bvalid_o, s_bready_o}), 32'd0);
    cyc(); clr();

    // Reset while RD_M0 has a response pending.
    m0_araddr_i = 32'h2000_0100; m0_arvalid_i = 1;
    cyc(); s_arready_i = 1;
    cyc(); m0_arvalid_i = 0; s_arready_i = 0; s_rvalid_i = 1; s_rdata_i = 32'hCAFE_0001;
    m0_rready_i = 1; rstn = 0;
    #1 chk("rst_mid_in_reset", 32'({m0_rvalid_o, s_rready_o}), 32'd0);
    cyc(); rstn = 1;
    #1 chk("rst_mid_after", 32'({m0_rvalid_o, s_rready_o, s_arvalid_o}), 32'd0);
    cyc(); clr();

    // m1 holds rready low: grant held, pending m0 request waits.
    m1_araddr_i = 32'h8000_0100; m1_arvalid_i = 1;
    cyc(); s_arready_i = 1;
    #1 chk("hold_araddr", s_araddr_o, 32'h8000_0100);
    cyc(); m1_arvalid_i = 0; s_arready_i = 0; m0_araddr_i = 32'h2000_0040; m0_arvalid_i = 1;
    s_rvalid_i = 1; s_rdata_i = 32'h0BAD_F00D; m1_rready_i = 0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("hold_grant", 32'({m1_rvalid_o, s_rready_o, s_arvalid_o, m0_arready_o}), 32'd8);
      cyc();
    end
    m1_rready_i = 1;
    #1;
    chk("hold_release", 32'(s_rready_o), 32'd1);
    chk("hold_rdata", m1_rdata_o, 32'h0BAD_F00D);
    cyc(); s_rvalid_i = 0; m1_rready_i = 0;
    #1 chk("hold_gap_idle", 32'(s_arvalid_o), 32'd0);
    cyc(); s_arready_i = 1;
    #1;
    chk("hold_m0_grant", 32'(s_arvalid_o), 32'd1);
    chk("hold_m0_addr", s_araddr_o, 32'h2000_0040);
    cyc(); m0_arvalid_i = 0; s_arready_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h1111_2222;
    s_rresp_i = 2'b11; m0_rready_i = 1;
    #1;
    chk("hold_m0_rdata", m0_rdata_o, 32'h1111_2222);
    chk("hold_m0_rresp", 32'(m0_rresp_o), 32'd3);
    cyc(); clr();
    cyc();

    run_random(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
